// File: rtl/lcd_ctrl.sv
// lcd_ctrl: 4-entry FIFO feeding a character-LCD write sequencer with
// timed setup / enable / hold / execute phases and a status readback word.
module lcd_ctrl #(
    parameter int SETUP_CYC = 2,
    parameter int EN_CYC    = 12,
    parameter int HOLD_CYC  = 2,
    parameter int EXEC_CYC  = 2000,
    parameter int CLEAR_CYC = 80000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wr_en_i,
    input  logic [31:0] wr_data_i,
    output logic [31:0] status_o,
    output logic [7:0]  lcd_data_o,
    output logic        lcd_rs_o,
    output logic        lcd_rw_o,
    output logic        lcd_en_o,
    output logic        lcd_on_o
);
    localparam int M1   = SETUP_CYC > EN_CYC ? SETUP_CYC : EN_CYC;
    localparam int M2   = HOLD_CYC > EXEC_CYC ? HOLD_CYC : EXEC_CYC;
    localparam int M3   = M1 > M2 ? M1 : M2;
    localparam int MAXC = M3 > CLEAR_CYC ? M3 : CLEAR_CYC;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, EXEC} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [8:0]    mem_q [4];
    logic [8:0]    mem_d [4];
    logic [1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [2:0]    count_q, count_d;
    logic          ovf_q, ovf_d, on_q, on_d, en_q, en_d, rs_q, rs_d;
    logic [7:0]    data_q, data_d;
    logic          ctrl, full, pop, push, slow, busy;

    assign ctrl = wr_data_i[30];
    assign full = count_q == 3'd4;
    assign pop  = state_q == IDLE && count_q != 3'd0;
    // A full FIFO still accepts a write when the same edge pops an entry.
    assign push = wr_en_i && !ctrl && (!full || pop);
    assign slow = !rs_q && (data_q == 8'h01 || data_q == 8'h02);
    assign busy = state_q != IDLE || count_q != 3'd0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (pop) begin
                state_d = SETUP;
                cnt_d   = CW'(SETUP_CYC - 1);
            end
            SETUP: if (cnt_q == '0) begin
                state_d = PULSE;
                cnt_d   = CW'(EN_CYC - 1);
            end else cnt_d = cnt_q - CW'(1);
            PULSE: if (cnt_q == '0) begin
                state_d = HOLD;
                cnt_d   = CW'(HOLD_CYC - 1);
            end else cnt_d = cnt_q - CW'(1);
            HOLD: if (cnt_q == '0) begin
                state_d = EXEC;
                cnt_d   = slow ? CW'(CLEAR_CYC - 1) : CW'(EXEC_CYC - 1);
            end else cnt_d = cnt_q - CW'(1);
            EXEC: if (cnt_q == '0) state_d = IDLE;
                  else cnt_d = cnt_q - CW'(1);
            default: state_d = IDLE;
        endcase
    end

    // EN is registered from the next state so it is a clean flop output.
    always_comb begin
        en_d = state_d == PULSE;
    end

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_q] = wr_data_i[8:0];
        wr_d    = push ? wr_q + 2'd1 : wr_q;
        rd_d    = pop ? rd_q + 2'd1 : rd_q;
        count_d = count_q + {2'b0, push} - {2'b0, pop};
        ovf_d   = (wr_en_i && !ctrl && full && !pop) ? 1'b1 :
                  (wr_en_i && ctrl && wr_data_i[29]) ? 1'b0 : ovf_q;
        on_d    = (wr_en_i && ctrl) ? wr_data_i[31] : on_q;
        {rs_d, data_d} = pop ? mem_q[rd_q] : {rs_q, data_q};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q   <= '{default: '0};
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            on_q    <= 1'b0;
            en_q    <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            mem_q   <= mem_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            on_q    <= on_d;
            en_q    <= en_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
        end
    end

    assign status_o   = {25'd0, count_q, 1'b0, ovf_q, full, busy};
    assign lcd_data_o = data_q;
    assign lcd_rs_o   = rs_q;
    assign lcd_rw_o   = 1'b0;
    assign lcd_en_o   = en_q;
    assign lcd_on_o   = on_q;
endmodule

// File: doc/lcd_ctrl.md
LCD_CTRL -- requirements
Module: lcd_ctrl

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 2, cycles of RS/data valid before EN rises.
REQ-002 SHALL have parameter EN_CYC, default 12, cycles EN is held high.
REQ-003 SHALL have parameter HOLD_CYC, default 2, cycles RS/data are held after EN falls.
REQ-004 SHALL have parameter EXEC_CYC, default 2000, wait cycles after a normal command or data byte.
REQ-005 SHALL have parameter CLEAR_CYC, default 80000, wait cycles after clear (0x01) or home (0x02) commands.
REQ-006 SHALL use one clock and an asynchronous, active-high reset; the ports are named clk_i and rst_i.
REQ-007 clk_i  in  1  system clock, rising edge.
REQ-008 rst_i  in  1  asynchronous active-high reset.
REQ-009 wr_en_i  in  1  store strobe to the LCD address, sampled at the rising edge.
REQ-010 wr_data_i  in  32  store word: [30] control select, [31] LCD on, [29] clear overflow, [8] RS, [7:0] byte.
REQ-011 status_o  out  32  load readback: [0] busy, [1] full, [2] overflow, [6:4] FIFO count, other bits 0.
REQ-012 lcd_data_o  out  8  LCD data bus.
REQ-013 lcd_rs_o  out  1  register select (0 command, 1 data).
REQ-014 lcd_rw_o  out  1  read/write; tied to 0 (write-only).
REQ-015 lcd_en_o  out  1  LCD enable strobe.
REQ-016 lcd_on_o  out  1  LCD power/backlight enable.

Function
REQ-017 A write with wr_data_i[30]=1 is a control write: lcd_on_o <= [31]; [29]=1 clears overflow; nothing is enqueued.
REQ-018 A write with [30]=0 enqueues {[8],[7:0]} into a 4-entry FIFO when not full.
REQ-019 A write while full, with no pop in the same cycle, is dropped and sets overflow (sticky).
REQ-020 A write while full with a pop in the same cycle is accepted; count stays 4.
REQ-021 FSM states: IDLE, SETUP, PULSE, HOLD, EXEC.
REQ-022 IDLE with the FIFO non-empty pops one entry at the next edge, loads lcd_rs_o/lcd_data_o, and goes to SETUP.
REQ-023 There is no bypass: a write into an empty FIFO is popped no earlier than the following edge.
REQ-024 SETUP lasts SETUP_CYC cycles, then PULSE.
REQ-025 PULSE drives lcd_en_o=1 for exactly EN_CYC cycles, then HOLD.
REQ-026 HOLD lasts HOLD_CYC cycles with EN low and RS/data unchanged, then EXEC.
REQ-027 EXEC waits CLEAR_CYC cycles if RS=0 and the byte is 0x01 or 0x02, otherwise EXEC_CYC cycles; it then returns to IDLE.
REQ-028 lcd_rs_o and lcd_data_o change only on a pop and otherwise hold their last value.
REQ-029 lcd_en_o is registered, glitch-free, and high only in PULSE.
REQ-030 busy = (FSM != IDLE) or (count != 0).
REQ-031 status_o reflects state registered at the preceding edge.
REQ-032 A control write is accepted in any FSM state and never disturbs an in-progress transfer.
REQ-033 FIFO pointers wrap modulo 4; count saturates at 0 and 4 and never underflows.
REQ-034 Phase counters are wide enough for CLEAR_CYC; a parameter value of 0 is illegal.

Reset
REQ-035 While rst_i=1, asynchronously: FSM=IDLE, FIFO empty, overflow=0, lcd_en_o=0, lcd_rs_o=0, lcd_data_o=0x00, lcd_on_o=0, lcd_rw_o=0, status_o=0.
REQ-036 Reset asserted mid-transfer drops lcd_en_o immediately and discards all queued entries.
REQ-037 After reset deasserts, the first wr_en_i sampled at a rising edge is honoured.

Verification (params SETUP=1, EN=2, HOLD=1, EXEC=4, CLEAR=10)
REQ-038 Reset, then write 0x0000_0141: the pop loads RS=1, data=0x41; EN is high for exactly 2 cycles, 1 cycle after the pop; busy clears 1+2+1+4 cycles after the pop.
REQ-039 Write 0x0000_0001: the EXEC phase lasts 10 cycles; busy stays 1 throughout.
REQ-040 Six back-to-back data writes during EXEC of a prior byte: overflow=1, full=1, count=4; the accepted bytes emerge in order; later write 0x2000_0000 plus [30]=1 clears overflow.
REQ-041 Write 0xC000_0000: lcd_on_o=1 next cycle, FIFO count unchanged, no EN pulse.
REQ-042 Assert rst_i while lcd_en_o=1 with 2 entries queued: EN=0 and status_o=0 without waiting for a clock edge; no further EN pulses occur after release.
